mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, synchronous unified memory between the CPU instruction-fetch port and the CPU data port.
- Data accesses have priority. A starvation counter guarantees fetch progress.
- Read data returns one cycle after grant and is routed to the port that issued the read.
- Sits between the pipelined core (`pc`/`instr` and `mem_addr`/`mem_wdata`/`mem_write`/`mem_rdata`) and the memory macro. The core uses `i_gnt`/`d_gnt` to derive its fetch and memory-stage stalls.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, number of consecutive data grants allowed while fetch waits before fetch is forced; range 1..15

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- i_req  input  1  fetch request, held until granted
- i_addr  input  AW  fetch address
- i_gnt  output  1  fetch granted this cycle
- i_rvalid  output  1  fetch read data valid
- i_rdata  output  DW  fetch read data
- d_req  input  1  data request, held until granted
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  data address
- d_wdata  input  DW  write data
- d_gnt  output  1  data granted this cycle
- d_rvalid  output  1  data read data valid (reads only)
- d_rdata  output  DW  data read data
- m_en  output  1  memory access enable
- m_we  output  1  memory write enable
- m_addr  output  AW  memory address
- m_wdata  output  DW  memory write data
- m_rdata  input  DW  memory read data, valid the cycle after m_en & ~m_we

Behaviour:
- Reset value of every output: i_gnt, d_gnt, i_rvalid, d_rvalid, m_en and m_we are 0 while reset is high. Data outputs follow their combinational sources. starve_cnt = 0; resp_tag = NONE.
- Grants are combinational from the req inputs and registered state. A request is granted in the same cycle it is presented if it wins. At most one grant per cycle.
- Arbitration:
  - only i_req: grant I
  - only d_req: grant D
  - both, with starve_cnt < STARVE_MAX: grant D
  - both, with starve_cnt == STARVE_MAX: grant I
  - neither: no grant, m_en = 0
- Memory mux:
  - m_en = i_gnt | d_gnt
  - m_we = d_gnt & d_we
  - m_addr = selected address
  - m_wdata = d_wdata
  - m_we is never 1 on a fetch grant.
- starve_cnt, on each rising edge:
  - i_gnt, or i_req low: clear to 0
  - d_gnt while i_req high: increment, saturating at STARVE_MAX
- resp_tag, next value:
  - I if i_gnt
  - D if d_gnt & ~d_we
  - else NONE
- Responses:
  - i_rvalid = (resp_tag == I); d_rvalid = (resp_tag == D)
  - i_rdata = d_rdata = m_rdata (pass-through)
  - Read latency is exactly 1 cycle from grant. A write produces no rvalid.
- Back-to-back operation: a new grant is allowed in the same cycle as the previous response. Full throughput is 1 access per cycle.
- Requester rules:
  - Address, data and d_we are stable while req is high and not granted.
  - After a grant, the requester may drop req or present a new request the next cycle.
  - req dropped before grant: the request is abandoned, with no side effect.
- Reset mid-operation: an in-flight read response is discarded and rvalid is 0 from reset assertion onward. The counter clears. The first grant is possible in the first cycle after reset deasserts.
- Simultaneous events: the arbitration order above is total, so no other tie cases exist.

Test Plan:
- Reset, then i_req=1, i_addr=0x10 with memory[0x10]=0xDEADBEEF → i_gnt=1, m_addr=0x10, m_we=0 in the same cycle. Next cycle i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
- d_req with d_we=1, d_addr=0x40, d_wdata=0x12345678, then a read of 0x40 on the next cycle → the write cycle has m_we=1 and no rvalid. The read returns d_rvalid=1, d_rdata=0x12345678 one cycle after its grant.
- i_req and d_req held high continuously, STARVE_MAX=4 → grant pattern is D,D,D,D,I repeating. starve_cnt goes 0→4, then clears on the I grant.
- Alternating fetch and data reads on consecutive cycles → every cycle has m_en=1. Responses arrive tagged correctly with no gaps, and the I and D rvalids are never high together.
- Fetch read granted, reset asserted before the response edge → i_rvalid stays 0. After release with i_req=1, grant occurs in the first cycle.
- d_req=1 with d_we=0, dropped to 0 before grant because i_req wins at starvation → no memory access is made for D, and d_rvalid stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported synchronous memory between the CPU instruction
// fetch port (I) and the CPU data port (D). Data accesses win by default; a
// starvation counter forces a fetch grant once STARVE_MAX data grants in a
// row have been issued while fetch was waiting. Grants are combinational so
// a winning request is serviced in the cycle it is presented. Read data
// arrives from the memory one cycle after the grant and is steered back to
// whichever port issued the read.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   i_req, i_addr           fetch request / address (held until granted)
//   i_gnt                   fetch granted this cycle
//   i_rvalid, i_rdata       fetch read response
//   d_req, d_we, d_addr,
//   d_wdata                 data request (held until granted)
//   d_gnt                   data granted this cycle
//   d_rvalid, d_rdata       data read response (reads only)
//   m_en, m_we, m_addr,
//   m_wdata                 memory command
//   m_rdata                 memory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    // Which port owns the read data coming back from memory next cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    logic [CW-1:0] starve_q, starve_d;
    tag_e          tag_q, tag_d;

    logic          starved;
    logic          i_gnt_w;
    logic          d_gnt_w;

    assign starved = (starve_q == CW'(STARVE_MAX));

    // Arbitration. Grants are forced low during reset so that the memory
    // sees no access while the block is held.
    always_comb begin
        i_gnt_w = 1'b0;
        d_gnt_w = 1'b0;
        if (!reset) begin
            i_gnt_w = i_req & (~d_req | starved);
            d_gnt_w = d_req & ~i_gnt_w;
        end
    end

    assign i_gnt = i_gnt_w;
    assign d_gnt = d_gnt_w;

    // Memory command mux. A fetch grant never writes.
    assign m_en    = i_gnt_w | d_gnt_w;
    assign m_we    = d_gnt_w & d_we;
    assign m_addr  = d_gnt_w ? d_addr : i_addr;
    assign m_wdata = d_wdata;

    // Response routing: the memory read data is shared, only the valids
    // distinguish the destination.
    assign i_rvalid = (tag_q == TAG_I);
    assign d_rvalid = (tag_q == TAG_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    // Next-state: the counter only tracks data grants that overtook a
    // waiting fetch, and resets as soon as fetch is served or goes idle.
    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt_w) begin
            starve_d = '0;
        end else if (d_gnt_w && !starved) begin
            starve_d = starve_q + CW'(1);
        end

        tag_d = TAG_NONE;
        if (i_gnt_w) begin
            tag_d = TAG_I;
        end else if (d_gnt_w && !d_we) begin
            tag_d = TAG_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            tag_q    <= TAG_NONE;
        end else begin
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: synchronous single port, 256 words.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (m_en && !m_we) m_rdata <= mem[m_addr[7:0]];
        if (m_en && m_we)  mem[m_addr[7:0]] <= m_wdata;
    end

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [256];
    int            cnt = 0;          // data grants that overtook a waiting fetch
    int            pend = 0;         // 0 none, 1 fetch response due, 2 data response due
    logic [DW-1:0] pend_data = '0;
    logic          ig_last = 1'b0;
    logic          dg_last = 1'b0;

    always @(negedge clk) begin
        logic eig, edg;
        if (reset) begin
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_m_en", m_en, 0);
            chk("rst_m_we", m_we, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            cnt = 0; pend = 0; ig_last = 0; dg_last = 0;
        end else begin
            eig = i_req && (!d_req || cnt == SM);
            edg = d_req && !eig;
            chk("i_gnt", i_gnt, eig);
            chk("d_gnt", d_gnt, edg);
            chk("m_en", m_en, eig || edg);
            chk("m_we", m_we, edg && d_we);
            if (eig) chk("m_addr_i", m_addr, i_addr);
            if (edg) chk("m_addr_d", m_addr, d_addr);
            if (edg && d_we) chk("m_wdata", m_wdata, d_wdata);
            chk("i_rvalid", i_rvalid, pend == 1);
            chk("d_rvalid", d_rvalid, pend == 2);
            if (pend == 1) chk("i_rdata", i_rdata, pend_data);
            if (pend == 2) chk("d_rdata", d_rdata, pend_data);
            // advance to the state seen after the coming rising edge
            pend = 0;
            if (eig) begin
                pend = 1; pend_data = ref_mem[i_addr[7:0]];
            end else if (edg && !d_we) begin
                pend = 2; pend_data = ref_mem[d_addr[7:0]];
            end
            if (edg && d_we) ref_mem[d_addr[7:0]] = d_wdata;
            if (!i_req || eig) cnt = 0;
            else if (edg && cnt < SM) cnt = cnt + 1;
            ig_last = eig; dg_last = edg;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    byte pat [10] = '{"D","D","D","D","I","D","D","D","D","I"};

    initial begin
        byte g;
        logic prev_i;
        for (int k = 0; k < 256; k++) begin
            mem[k]     = 32'hA500_0000 ^ (k * 32'h0101_0101);
            ref_mem[k] = 32'hA500_0000 ^ (k * 32'h0101_0101);
        end
        mem[8'h10]     = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;

        repeat (3) cyc();
        #5;
        chk("lit_rst_m_en", m_en, 0);
        chk("lit_rst_rvalid", {i_rvalid, d_rvalid}, 0);

        // fetch read
        cyc(); reset = 0; i_req = 1; i_addr = 32'h10; #5;
        chk("lit_fetch_gnt", i_gnt, 1);
        chk("lit_fetch_addr", m_addr, 32'h10);
        chk("lit_fetch_we", m_we, 0);
        cyc(); i_req = 0; #5;
        chk("lit_fetch_rvalid", i_rvalid, 1);
        chk("lit_fetch_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("lit_fetch_d_rvalid", d_rvalid, 0);

        // write then read back
        cyc(); d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h1234_5678; #5;
        chk("lit_wr_gnt", d_gnt, 1);
        chk("lit_wr_we", m_we, 1);
        cyc(); d_we = 0; d_wdata = 32'h0; #5;
        chk("lit_rd_gnt", d_gnt, 1);
        chk("lit_wr_no_rvalid", {i_rvalid, d_rvalid}, 0);
        cyc(); d_req = 0; #5;
        chk("lit_rd_rvalid", d_rvalid, 1);
        chk("lit_rd_rdata", d_rdata, 32'h1234_5678);

        // starvation: both held, expect D,D,D,D,I repeating
        cyc(); i_req = 1; i_addr = 32'h11; d_req = 1; d_we = 0; d_addr = 32'h22;
        for (int k = 0; k < 10; k++) begin
            #5;
            g = i_gnt ? "I" : (d_gnt ? "D" : "-");
            chk($sformatf("lit_starve_%0d", k), g, pat[k]);
            cyc();
            if (k == 4) i_addr = 32'h12;
        end
        // the last grant went to I while D waited; D now abandons its read
        i_req = 0; d_req = 0; #5;
        chk("lit_abandon_i_rvalid", i_rvalid, 1);
        chk("lit_abandon_d_rvalid", d_rvalid, 0);
        chk("lit_abandon_m_en", m_en, 0);
        cyc(); #5;
        chk("lit_abandon_d_rvalid2", d_rvalid, 0);

        // alternating fetch / data reads
        prev_i = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            i_req = (k % 2 == 0); d_req = (k % 2 == 1); d_we = 0;
            i_addr = k; d_addr = 32'h80 + k;
            #5;
            chk("lit_alt_m_en", m_en, 1);
            chk("lit_alt_both", i_rvalid && d_rvalid, 0);
            if (k > 0) chk("lit_alt_tag", {i_rvalid, d_rvalid}, prev_i ? 2'b10 : 2'b01);
            prev_i = i_gnt;
        end

        // reset between grant and response
        cyc(); i_req = 1; i_addr = 32'h10; d_req = 0; #5;
        chk("lit_rstmid_gnt", i_gnt, 1);
        #2 reset = 1;
        cyc(); i_req = 0; #5;
        chk("lit_rstmid_rvalid", i_rvalid, 0);
        cyc(); reset = 0; i_req = 1; i_addr = 32'h20; #5;
        chk("lit_rstmid_first_gnt", i_gnt, 1);
        cyc(); i_req = 0; #5;
        chk("lit_rstmid_rdata", i_rdata, 32'h8520_2020);
        chk("lit_rstmid_rvalid2", i_rvalid, 1);

        // randomized traffic obeying the requester rules
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if ($urandom_range(299) == 0) reset = 1;
            else reset = 0;
            if (i_req && !ig_last) begin
                if ($urandom_range(9) == 0) i_req = 0;
            end else begin
                i_req  = ($urandom_range(9) < 6);
                i_addr = $urandom_range(255);
            end
            if (d_req && !dg_last) begin
                if ($urandom_range(9) == 0) d_req = 0;
            end else begin
                d_req   = ($urandom_range(9) < 6);
                d_we    = $urandom_range(1);
                d_addr  = $urandom_range(255);
                d_wdata = $urandom;
            end
        end
        cyc(); reset = 0; i_req = 0; d_req = 0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
